// File: rtl/mdu_pkg.sv
// Shared op codes and helpers for the multiply/divide unit.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_pkg;

   localparam int CNT_W = 4;

   localparam logic [3:0] MDU_NOP   = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MTHI  = 4'd5;
   localparam logic [3:0] MDU_MTLO  = 4'd6;
   localparam logic [3:0] MDU_MADD  = 4'd7;
   localparam logic [3:0] MDU_MADDU = 4'd8;
   localparam logic [3:0] MDU_MSUB  = 4'd9;
   localparam logic [3:0] MDU_MSUBU = 4'd10;

   function automatic logic mdu_is_mul(input logic [3:0] op);
      logic r;
      r = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
      r = r || (op == MDU_MADD) || (op == MDU_MADDU) ||
               (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
      return r;
   endfunction

   function automatic logic mdu_is_div(input logic [3:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational result generator: computes the HI/LO update for one op.
// MDU_MADD_EN adds the accumulate/subtract-from-HI/LO ops.
module mdu_core
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] new_hi,
   output logic [WIDTH-1:0] new_lo,
   output logic             write_en
);

   logic [2*WIDTH-1:0] prod_s, prod_u;
   logic [WIDTH-1:0]   div_b, q_u, r_u, mag_a, mag_b, q_m, r_m, q_s, r_s;

   always_comb begin
      prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});

      // Divisor forced non-zero so the datapath never divides by zero; the
      // write is suppressed for that case anyway.
      div_b = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
      q_u   = a / div_b;
      r_u   = a % div_b;

      // Sign-magnitude division: INT_MIN/-1 falls out as INT_MIN rem 0.
      mag_a = a[WIDTH-1] ? -a : a;
      mag_b = div_b[WIDTH-1] ? -div_b : div_b;
      q_m   = mag_a / mag_b;
      r_m   = mag_a % mag_b;
      q_s   = (a[WIDTH-1] ^ div_b[WIDTH-1]) ? -q_m : q_m;
      r_s   = a[WIDTH-1] ? -r_m : r_m;

      new_hi   = hi;
      new_lo   = lo;
      write_en = 1'b0;
      case (op)
         MDU_MULT:  begin {new_hi, new_lo} = prod_s; write_en = 1'b1; end
         MDU_MULTU: begin {new_hi, new_lo} = prod_u; write_en = 1'b1; end
         MDU_DIV:   begin new_hi = r_s; new_lo = q_s; write_en = (b != '0); end
         MDU_DIVU:  begin new_hi = r_u; new_lo = q_u; write_en = (b != '0); end
         MDU_MTHI:  begin new_hi = a; write_en = 1'b1; end
         MDU_MTLO:  begin new_lo = a; write_en = 1'b1; end
`ifdef MDU_MADD_EN
         MDU_MADD:  begin {new_hi, new_lo} = {hi, lo} + prod_s; write_en = 1'b1; end
         MDU_MADDU: begin {new_hi, new_lo} = {hi, lo} + prod_u; write_en = 1'b1; end
         MDU_MSUB:  begin {new_hi, new_lo} = {hi, lo} - prod_s; write_en = 1'b1; end
         MDU_MSUBU: begin {new_hi, new_lo} = {hi, lo} - prod_u; write_en = 1'b1; end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
//
//   state               | meaning
//   idle (cnt_q == 0)   | accepts start; MTHI/MTLO write HI/LO at once
//   run  (cnt_q != 0)   | down-counting; HI/LO written on the 1->0 edge
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic [3:0]       op,
   input  logic             start,
   input  logic             flush,
   output logic             busy,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic [3:0]       op_q, op_d;
   logic             busy_q, busy_d;

   logic [3:0]       core_op;
   logic [WIDTH-1:0] core_a, core_b, core_hi, core_lo;
   logic             core_we;

   // While running the core sees the latched operands; when idle it sees
   // the live inputs so MTHI/MTLO can complete at the accept edge.
   assign core_op = busy_q ? op_q : op;
   assign core_a  = busy_q ? a_q  : inA;
   assign core_b  = busy_q ? b_q  : inB;

   mdu_core #(.WIDTH(WIDTH)) u_core (
      .op       (core_op),
      .a        (core_a),
      .b        (core_b),
      .hi       (hi_q),
      .lo       (lo_q),
      .new_hi   (core_hi),
      .new_lo   (core_lo),
      .write_en (core_we)
   );

   always_comb begin
      cnt_d = cnt_q;
      a_d   = a_q;
      b_d   = b_q;
      op_d  = op_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      if (flush) begin
         cnt_d = '0;
      end else if (busy_q) begin
         cnt_d = cnt_q - CNT_ONE;
         if (cnt_q == CNT_ONE && core_we) begin
            hi_d = core_hi;
            lo_d = core_lo;
         end
      end else if (start) begin
         if (mdu_is_mul(op) || mdu_is_div(op)) begin
            op_d  = op;
            a_d   = inA;
            b_d   = inB;
            cnt_d = mdu_is_div(op) ? DIV_LOAD : MUL_LOAD;
         end else if (core_we) begin
            hi_d = core_hi;
            lo_d = core_lo;
         end
      end
      busy_d = (cnt_d != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= MDU_NOP;
         hi_q   <= '0;
         lo_q   <= '0;
         busy_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         a_q    <= a_d;
         b_q    <= b_d;
         op_q   <= op_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         busy_q <= busy_d;
      end
   end

   assign busy   = busy_q;
   assign hi_out = hi_q;
   assign lo_out = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed testbench for mdu_unit: vector table plus flush/reset sequences.
// Expectations for MADD/MSUB vectors follow MDU_MADD_EN.
module tb_mdu_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start, flush, busy;
   logic [3:0]  op;
   logic [31:0] inA, inB, hi_out, lo_out;

   int n_pass  = 0;
   int n_total = 0;
   int n;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pre_hi;
      logic [31:0] pre_lo;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          exp_busy;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   mdu_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .inA    (inA),
      .inB    (inB),
      .op     (op),
      .start  (start),
      .flush  (flush),
      .busy   (busy),
      .hi_out (hi_out),
      .lo_out (lo_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic launch(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      op    = o;
      inA   = a;
      inB   = b;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy !== 1'b0 && cycles < 40) begin
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
      launch(MDU_MTHI, h, 32'h0);
      launch(MDU_MTLO, l, 32'h0);
   endtask

   initial begin
      vecs[0]  = '{MDU_MULT,  32'hFFFFFFFE, 32'h3,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFA, 5};
      vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFE, 32'h3,        32'h0,  32'h0,  32'h00000002, 32'hFFFFFFFA, 5};
      vecs[2]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h0,  32'h0,  32'h40000000, 32'h00000000, 5};
      vecs[3]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h2,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[4]  = '{MDU_DIVU,  32'hFFFFFFF9, 32'h2,        32'h0,  32'h0,  32'h00000001, 32'h7FFFFFFC, 10};
      vecs[5]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5,  32'h5,  32'h00000000, 32'h80000000, 10};
      vecs[6]  = '{MDU_DIV,   32'h7,        32'hFFFFFFFE, 32'h0,  32'h0,  32'h00000001, 32'hFFFFFFFD, 10};
      vecs[7]  = '{MDU_DIVU,  32'h1234,     32'h0,        32'h11, 32'h22, 32'h00000011, 32'h00000022, 10};
      vecs[8]  = '{MDU_MTHI,  32'h1234,     32'h0,        32'h0,  32'h0,  32'h00001234, 32'h00000000, 0};
      vecs[9]  = '{MDU_MTLO,  32'h55,       32'h0,        32'h1,  32'h2,  32'h00000001, 32'h00000055, 0};
      vecs[10] = '{4'd11,     32'h9,        32'h9,        32'h5,  32'h6,  32'h00000005, 32'h00000006, 0};
`ifdef MDU_MADD_EN
      vecs[11] = '{MDU_MADDU, 32'h1,        32'h1,        32'h0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5};
      vecs[12] = '{MDU_MSUB,  32'h2,        32'h3,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFA, 5};
`else
      vecs[11] = '{MDU_MADDU, 32'h1,        32'h1,        32'h0,  32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0};
      vecs[12] = '{MDU_MSUB,  32'h2,        32'h3,        32'h0,  32'h0,  32'h00000000, 32'h00000000, 0};
`endif

      reset = 1'b1; start = 1'b0; flush = 1'b0;
      op = MDU_NOP; inA = 32'h0; inB = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_busy", {31'h0, busy}, 32'h0);
      check("reset_hi", hi_out, 32'h0);
      check("reset_lo", lo_out, 32'h0);

      for (int i = 0; i < NV; i++) begin
         set_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
         launch(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_idle(n);
         check($sformatf("v%0d_busy_cycles", i), 32'(n), 32'(vecs[i].exp_busy));
         check($sformatf("v%0d_hi", i), hi_out, vecs[i].exp_hi);
         check($sformatf("v%0d_lo", i), lo_out, vecs[i].exp_lo);
      end

      // MTLO issued while a divide-by-zero is running must be ignored.
      set_hilo(32'h66, 32'h77);
      launch(MDU_DIVU, 32'h5, 32'h0);
      @(negedge clk);
      op = MDU_MTLO; inA = 32'h99; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(n);
      check("busy_start_cycles", 32'(n), 32'd8);
      check("busy_start_hi", hi_out, 32'h66);
      check("busy_start_lo", lo_out, 32'h77);

      // Flush in busy cycle 3.
      set_hilo(32'hAA, 32'hBB);
      launch(MDU_MULT, 32'h2, 32'h3);
      repeat (2) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_mid_busy", {31'h0, busy}, 32'h0);
      check("flush_mid_hi", hi_out, 32'hAA);
      check("flush_mid_lo", lo_out, 32'hBB);
      repeat (6) @(negedge clk);
      check("flush_mid_lo_later", lo_out, 32'hBB);

      // Flush on the final edge suppresses the write.
      launch(MDU_MULT, 32'h2, 32'h3);
      repeat (4) @(negedge clk);
      check("flush_final_busy_before", {31'h0, busy}, 32'h1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_final_busy", {31'h0, busy}, 32'h0);
      check("flush_final_hi", hi_out, 32'hAA);
      check("flush_final_lo", lo_out, 32'hBB);

      // Flush coincident with start blocks both MTHI and multi-cycle ops.
      flush = 1'b1;
      launch(MDU_MTHI, 32'h5, 32'h0);
      flush = 1'b0;
      check("flush_start_mthi_hi", hi_out, 32'hAA);
      flush = 1'b1;
      launch(MDU_MULT, 32'h2, 32'h3);
      flush = 1'b0;
      check("flush_start_mult_busy", {31'h0, busy}, 32'h0);
      repeat (6) @(negedge clk);
      check("flush_start_mult_lo", lo_out, 32'hBB);

      // Operand changes during busy have no effect.
      launch(MDU_MULT, 32'h2, 32'h3);
      inA = 32'd100; inB = 32'd100;
      wait_idle(n);
      check("latched_ops_cycles", 32'(n), 32'd5);
      check("latched_ops_hi", hi_out, 32'h0);
      check("latched_ops_lo", lo_out, 32'h6);

      // Reset in busy cycle 2 discards the op and clears HI/LO.
      set_hilo(32'h12, 32'h34);
      launch(MDU_MULT, 32'h7, 32'h7);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("reset_mid_busy", {31'h0, busy}, 32'h0);
      check("reset_mid_hi", hi_out, 32'h0);
      check("reset_mid_lo", lo_out, 32'h0);
      repeat (6) @(negedge clk);
      check("reset_mid_lo_later", lo_out, 32'h0);
      check("reset_mid_busy_later", {31'h0, busy}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage beside the combinational ALU.
- Accepts one operation per start pulse and holds busy for a fixed, parametrised latency.
- The pipeline controller stalls any HI/LO-touching instruction in D while busy or start is high.
- Generalises width and latency, and adds flush/abort behaviour.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, busy cycles for MULT/MULTU/MADD*/MSUB* (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- inA  in  WIDTH  rs operand.
- inB  in  WIDTH  rt operand.
- op  in  4  operation code (package constants), sampled only when start=1.
- start  in  1  launch op this cycle.
- flush  in  1  abort in-flight op (exception/interrupt taken).
- busy  out  1  operation in progress.
- hi_out  out  WIDTH  current HI register.
- lo_out  out  WIDTH  current LO register.

Behaviour:
- Reset: HI=0, LO=0, busy=0, counter=0, latched operands/op=0. Reset mid-operation discards the op; reset has priority over flush and start.
- Op codes:
  - NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - MADD=7, MADDU=8, MSUB=9, MSUBU=10 are optional.
  - 11..15 are treated as NOP.
- Start accept:
  - Accepted on a rising edge with start=1, busy=0 and flush=0.
  - start while busy=1 is ignored, with no state change.
- MTHI/MTLO:
  - Written at the accept edge: HI<=inA or LO<=inA.
  - busy stays 0.
  - Visible on hi_out/lo_out in the next cycle.
- Multi-cycle ops:
  - The accept edge latches inA, inB and op, and loads the counter with MUL_CYCLES or DIV_CYCLES.
  - busy = (counter != 0), registered, so it is high for exactly N cycles starting the cycle after accept.
  - Each edge decrements the counter. At the edge where the counter goes 1->0, HI/LO are written and busy falls. Result is visible in the same cycle busy is first 0.
- Arithmetic:
  - MULT: {HI,LO} = signed inA * signed inB, full 2*WIDTH product.
  - MULTU: same as MULT, unsigned.
  - DIV: LO = quotient, HI = remainder. Truncation toward zero; remainder takes the sign of the dividend.
  - DIVU: same as DIV, unsigned.
  - Signed INT_MIN / -1 gives LO=INT_MIN, HI=0.
  - Divide by zero (inB=0 for DIV/DIVU): op runs full latency, HI/LO unchanged.
- Flush:
  - flush=1 at any edge clears the counter; busy=0 next cycle; HI/LO unchanged.
  - flush coincident with start: start is not accepted, including MTHI/MTLO.
  - flush coincident with the final (1->0) edge: write suppressed.
- Result uses latched operands. inA/inB changes during busy have no effect.
- hi_out/lo_out are direct register outputs. Intermediate values never appear.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - MADD: {HI,LO} += signed product.
  - MADDU: {HI,LO} += unsigned product.
  - MSUB: {HI,LO} -= signed product.
  - MSUBU: {HI,LO} -= unsigned product.
  - All four use MUL_CYCLES latency and modulo 2*WIDTH arithmetic.
  - The accumulator base is the HI/LO value at the final edge.
- Undefined: codes 7..10 decode as NOP, start is accepted, busy stays 0, HI/LO unchanged.

Decomposition:
- Package mdu_pkg: op code localparams (MDU_NOP..MDU_MSUBU) and counter width constant CNT_W=4.
- One sub-module, mdu_core: combinational result generator (op, a, b, hi, lo) -> {new_hi, new_lo, write_en}.
- mdu_unit holds the registers, counter, and flush/start control.

Test Plan:
- MULT inA=0xFFFFFFFE(-2), inB=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV inA=0xFFFFFFF9(-7), inB=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same inputs -> LO=0x7FFFFFFC, HI=1.
- DIV inA=0x80000000, inB=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU x/0 with prior HI=0x11, LO=0x22 -> both unchanged after 10 cycles.
- MTHI 0x1234 at an accept edge -> hi_out=0x1234 next cycle, busy never rises. MTLO issued while busy -> ignored.
- MULT started, flush asserted in busy cycle 3 -> busy=0 next cycle, HI/LO keep pre-op values. Reset in busy cycle 2 -> HI=LO=0, busy=0.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU 1*1 -> HI=1, LO=0. Without the macro -> same stimulus leaves HI=0, LO=0xFFFFFFFF, busy stays 0.
